// File: rtl/irq_pkg.sv
// Shared definitions for irq_controller: register offsets, bus FSM states
// and the byte-lane write-mask helper.
package irq_pkg;

  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_REG_EDGE    = 2'd2;
  localparam logic [1:0] IRQ_REG_ACTIVE  = 2'd3;

  typedef enum logic {IDLE, ACK} bus_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/irq_source.sv
// One interrupt source: optional input synchronizer, edge/level capture and
// pending state. Define IRQ_CONTROLLER_SYNC_EN to add a 2-flop synchronizer on src_i.
module irq_source (
  input  logic clk,
  input  logic reset_i,
  input  logic src_i,
  input  logic eoi_i,
  input  logic edge_mode,
  input  logic edge_chg,
  input  logic w1c,
  output logic pending,
  output logic pending_next
);
  logic src_s;
  logic src_prev;
  logic eoi_prev;

`ifdef IRQ_CONTROLLER_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Stage p0/p1: two-flop synchronizer for asynchronous peripherals
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= src_i;
      sync_p1 <= sync_p0;
    end
  end
  assign src_s = sync_p1;
`else
  assign src_s = src_i;
`endif

  // A mode change discards whatever was captured under the old mode; a new edge beats any clear.
  always_comb begin
    pending_next = pending;
    if (edge_chg)
      pending_next = 1'b0;
    else if (!edge_mode)
      pending_next = src_s;
    else if (src_s && !src_prev)
      pending_next = 1'b1;
    else if (w1c || (eoi_i && !eoi_prev))
      pending_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      src_prev <= 1'b0;
      eoi_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      src_prev <= src_s;
      eoi_prev <= eoi_i;
      pending  <= pending_next;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: PENDING/ENABLE/EDGE/ACTIVE registers on a
// sel/ack slave bus, driving the processor irq lines. Optional IRQ_CONTROLLER_SYNC_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC        = 32,
  parameter logic [31:0] RESET_EDGE_SEL = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] src_i,
  output logic [31:0] irq_o,
  input  logic [31:0] eoi_i,
  input  logic        sel_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        ack_o
);
  localparam logic [32:0] SRC_SPAN  = 33'd1 << NUM_SRC;
  localparam logic [31:0] IMPL_MASK = 32'(SRC_SPAN - 33'd1);

  bus_state_t  state;
  logic [31:0] enable_r, edge_r;
  logic [31:0] enable_nxt, edge_nxt, edge_chg, w1c;
  logic [31:0] pending, pending_nxt;
  logic [31:0] wmask, rd_val;
  logic        wr;
  logic        unused_ok;

  assign unused_ok = ^{addr_i[31:4], addr_i[1:0], src_i, eoi_i};

  // Writes are taken only on the IDLE-state access, and never while in reset.
  assign wr    = (state == IDLE) && sel_i && we_i && !reset_i;
  assign wmask = byte_mask(wr_mask_i) & IMPL_MASK;

  always_comb begin
    enable_nxt = enable_r;
    edge_nxt   = edge_r;
    w1c        = '0;
    if (wr) begin
      case (addr_i[3:2])
        IRQ_REG_PENDING: w1c        = data_in_i & wmask;
        IRQ_REG_ENABLE:  enable_nxt = (enable_r & ~wmask) | (data_in_i & wmask);
        IRQ_REG_EDGE:    edge_nxt   = (edge_r & ~wmask) | (data_in_i & wmask);
        default: ;
      endcase
    end
  end

  assign edge_chg = edge_nxt ^ edge_r;

  for (genvar n = 0; n < 32; n++) begin : g_bit
    if (n < NUM_SRC) begin : g_src
      irq_source u_src (
        .clk          (clk),
        .reset_i      (reset_i),
        .src_i        (src_i[n]),
        .eoi_i        (eoi_i[n]),
        .edge_mode    (edge_r[n]),
        .edge_chg     (edge_chg[n]),
        .w1c          (w1c[n]),
        .pending      (pending[n]),
        .pending_next (pending_nxt[n])
      );
    end else begin : g_none
      assign pending[n]     = 1'b0;
      assign pending_nxt[n] = 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i[3:2])
      IRQ_REG_PENDING: rd_val = pending;
      IRQ_REG_ENABLE:  rd_val = enable_r;
      IRQ_REG_EDGE:    rd_val = edge_r;
      IRQ_REG_ACTIVE:  rd_val = pending & enable_r;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= IDLE;
      ack_o      <= 1'b0;
      data_out_o <= '0;
      enable_r   <= '0;
      edge_r     <= RESET_EDGE_SEL & IMPL_MASK;
      irq_o      <= '0;
    end else begin
      enable_r <= enable_nxt;
      edge_r   <= edge_nxt;
      irq_o    <= pending_nxt & enable_nxt;
      case (state)
        IDLE: begin
          if (sel_i) begin
            if (!we_i) data_out_o <= rd_val;
            ack_o <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
